// File: rtl/cf_spi_target_pkg.sv
// rtl/cf_spi_target_pkg.sv - shared constants for the SPI target Wishbone peripheral
// Purpose: register index map, RIS bit positions, STATUS field positions, data width.
// Ports: none (package).
package cf_spi_target_pkg;

  localparam int DATA_W = 8;

  // Register index as decoded from adr_i[4:2]
  typedef enum logic [2:0] {
    REG_RXDATA = 3'd0,
    REG_TXDATA = 3'd1,
    REG_STATUS = 3'd2,
    REG_CTRL   = 3'd3,
    REG_IM     = 3'd4,
    REG_RIS    = 3'd5,
    REG_RSVD6  = 3'd6,
    REG_RSVD7  = 3'd7
  } reg_idx_t;

  localparam int RIS_RXNE = 0;
  localparam int RIS_OVR  = 1;
  localparam int RIS_UF   = 2;
  localparam int RIS_EOF  = 3;
  localparam int RIS_TXO  = 4;

  localparam int ST_BUSY     = 0;
  localparam int ST_RX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_TX_FULL  = 3;
  localparam int ST_LEVEL    = 4;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_FLUSH = 1;

endpackage

// File: rtl/cf_spi_target_fifo.sv
// rtl/cf_spi_target_fifo.sv - synchronous byte FIFO for received SPI frames
// Purpose: 2**FAW deep FIFO with flush; pushes when full and pops when empty are ignored.
// Ports: clk, rst (async, active high), flush, push/push_data, pop, head (current
//        front entry), full, empty, level (0..2**FAW).
module cf_spi_target_fifo
  import cf_spi_target_pkg::*;
#(
  parameter int FAW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [FAW:0]      level
);

  localparam int DEPTH = 1 << FAW;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [FAW-1:0]    wptr;
  logic [FAW-1:0]    rptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == (FAW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      level <= level + (FAW+1)'(do_push) - (FAW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/cf_spi_target_wb.sv
// rtl/cf_spi_target_wb.sv - SPI mode-0 target with Wishbone register file and IRQ
// Purpose: samples an external SPI bus (MSB first, 8-bit frames), queues received bytes
//          in an RX FIFO and shifts out a TX holding byte on MISO.
// Ports: clk_i/rst_i system clock and async active-high reset; adr_i/dat_i/dat_o/sel_i/
//        cyc_i/stb_i/we_i/ack_o Wishbone slave; IRQ level interrupt; sclk/csb/mosi
//        asynchronous SPI inputs; miso and its active-low enable miso_oeb.
module cf_spi_target_wb
  import cf_spi_target_pkg::*;
#(
  parameter int         FAW     = 2,
  parameter logic [7:0] IDLE_TX = 8'hFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic [3:0]  sel_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  output logic        ack_o,
  output logic        IRQ,
  input  logic        sclk,
  input  logic        csb,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oeb
);

  // Synchronizers: index 1 is the synchronized value, index 2 its one-clk-old copy
  logic [2:0] sclk_sy;
  logic [2:0] csb_sy;
  logic [1:0] mosi_sy;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_sy <= 3'b000;
      csb_sy  <= 3'b111;
      mosi_sy <= 2'b00;
    end else begin
      sclk_sy <= {sclk_sy[1:0], sclk};
      csb_sy  <= {csb_sy[1:0], csb};
      mosi_sy <= {mosi_sy[0], mosi};
    end
  end

  logic csb_s, mosi_s, sclk_rise, sclk_fall, csb_rise, csb_fall;
  assign csb_s     = csb_sy[1];
  assign mosi_s    = mosi_sy[1];
  assign sclk_rise = sclk_sy[1] & ~sclk_sy[2];
  assign sclk_fall = ~sclk_sy[1] & sclk_sy[2];
  assign csb_rise  = csb_sy[1] & ~csb_sy[2];
  assign csb_fall  = ~csb_sy[1] & csb_sy[2];

  // State
  logic                en;
  logic [4:0]          im;
  logic [4:1]          ris_st;
  logic [7:0]          tx_hold;
  logic                tx_full;
  logic [7:0]          tx_byte;
  logic [7:0]          rx_shift;
  logic [2:0]          bit_cnt;
  logic                load_d;

  logic [DATA_W-1:0]   fifo_head;
  logic                fifo_full, fifo_empty;
  logic [FAW:0]        fifo_level;

  // Bus decode
  reg_idx_t idx;
  logic     req, wr, rd;
  assign idx = reg_idx_t'(adr_i[4:2]);
  assign req = cyc_i & stb_i & ~ack_o;
  assign wr  = req & we_i & sel_i[0];
  assign rd  = req & ~we_i;

  // Bit engine events; csb rise beats a coincident sclk rise, csb fall beats sclk rise
  logic ev_csb_rise, ev_csb_fall, ev_bit, wrap, tx_load;
  assign ev_csb_rise = en & csb_rise;
  assign ev_csb_fall = en & csb_fall;
  assign ev_bit      = en & sclk_rise & ~csb_s & ~csb_fall;
  assign wrap        = ev_bit & (bit_cnt == 3'd7);
  assign tx_load     = ev_csb_fall | wrap;

  logic fifo_push, fifo_pop, flush, tx_wr;
  assign fifo_push = wrap & ~fifo_full;
  assign fifo_pop  = rd & (idx == REG_RXDATA) & ~fifo_empty;
  assign flush     = wr & (idx == REG_CTRL) & dat_i[CTRL_FLUSH];
  assign tx_wr     = wr & (idx == REG_TXDATA);

  logic [4:1] ris_set, ris_clr;
  logic [4:0] ris;
  assign ris_set = {tx_wr & tx_full, ev_csb_rise, tx_load & ~tx_full, wrap & fifo_full};
  assign ris_clr = (wr && idx == REG_RIS) ? dat_i[4:1] : 4'b0;
  assign ris     = {ris_st, ~fifo_empty};

  assign IRQ      = |(ris & im);
  assign miso_oeb = ~(en & ~csb_s);

  cf_spi_target_fifo #(.FAW(FAW)) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (flush),
    .push      (fifo_push),
    .push_data ({rx_shift[6:0], mosi_s}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Bit engine
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_byte  <= '0;
      load_d   <= 1'b0;
      miso     <= 1'b1;
    end else begin
      load_d <= ev_csb_fall;
      if (!en || ev_csb_rise || ev_csb_fall) begin
        bit_cnt <= '0;
      end else if (ev_bit) begin
        rx_shift <= {rx_shift[6:0], mosi_s};
        bit_cnt  <= bit_cnt + 3'd1;
      end
      if (tx_load) tx_byte <= tx_full ? tx_hold : IDLE_TX;
      // First bit goes out one clk after the frame's byte is loaded
      if (load_d)                          miso <= tx_byte[7];
      else if (en && sclk_fall && !csb_s)  miso <= tx_byte[3'd7 - bit_cnt];
    end
  end

  // TX holding register; a load and a write in the same clk see the old full flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_hold <= '0;
      tx_full <= 1'b0;
    end else begin
      if (tx_load && tx_full) tx_full <= 1'b0;
      if (tx_wr && !tx_full) begin
        tx_hold <= dat_i[7:0];
        tx_full <= 1'b1;
      end
    end
  end

  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    case (idx)
      REG_RXDATA: rdata[7:0] = fifo_empty ? 8'h00 : fifo_head;
      REG_STATUS: rdata[FAW+4:0] = {fifo_level, tx_full, fifo_full, fifo_empty, en & ~csb_s};
      REG_CTRL:   rdata[CTRL_EN] = en;
      REG_IM:     rdata[4:0] = im;
      REG_RIS:    rdata[4:0] = ris;
      default:    rdata = '0;
    endcase
  end

  // Register file and bus response; set beats clear on RIS
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_o  <= 1'b0;
      dat_o  <= '0;
      en     <= 1'b0;
      im     <= '0;
      ris_st <= '0;
    end else begin
      ack_o  <= req;
      if (req) dat_o <= we_i ? 32'h0 : rdata;
      if (wr && idx == REG_CTRL) en <= dat_i[CTRL_EN];
      if (wr && idx == REG_IM)   im <= dat_i[4:0];
      ris_st <= (ris_st & ~ris_clr) | ris_set;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{adr_i[31:5], adr_i[1:0], dat_i[31:8], sel_i[3:1]};

endmodule

// File: tb/tb_cf_spi_target_wb.sv
// tb/tb_cf_spi_target_wb.sv - self-checking bench for cf_spi_target_wb
module tb_cf_spi_target_wb;

  localparam int H     = 6;
  localparam int DEPTH = 4;

  logic        clk = 0;
  logic        rst_i = 1;
  logic [31:0] adr_i = 0, dat_i = 0;
  logic [31:0] dat_o;
  logic [3:0]  sel_i = 4'hF;
  logic        cyc_i = 0, stb_i = 0, we_i = 0;
  logic        ack_o, IRQ, miso, miso_oeb;
  logic        sclk = 0, csb = 1, mosi = 0;

  always #5 clk = ~clk;

  cf_spi_target_wb #(.FAW(2), .IDLE_TX(8'hFF)) dut (
    .clk_i(clk), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .sel_i(sel_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .ack_o(ack_o),
    .IRQ(IRQ), .sclk(sclk), .csb(csb), .mosi(mosi), .miso(miso), .miso_oeb(miso_oeb)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference model: byte queue, TX holding slot, sticky flags
  logic [7:0] mq[$];
  logic       m_en, m_full, m_ovr, m_uf, m_eof, m_txo;
  logic [7:0] m_hold, m_cur;
  logic [4:0] m_im;
  logic [7:0] fb [8];

  function automatic logic [4:0] m_ris();
    return {m_txo, m_eof, m_uf, m_ovr, mq.size() != 0};
  endfunction

  task automatic m_reset();
    mq.delete();
    m_en = 0; m_full = 0; m_ovr = 0; m_uf = 0; m_eof = 0; m_txo = 0;
    m_hold = 0; m_cur = 0; m_im = 0;
  endtask

  task automatic m_load();
    if (m_full) begin m_cur = m_hold; m_full = 0; end
    else begin m_cur = 8'hFF; m_uf = 1; end
  endtask

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] r);
    bit got = 0;
    @(posedge clk); #1;
    cyc_i = 1; stb_i = 1; we_i = w; adr_i = a; dat_i = d;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack_o) begin got = 1; break; end
    end
    if (!got) chk("ack_timeout", 0, 1);
    r = dat_o;
    cyc_i = 0; stb_i = 0; we_i = 0;
  endtask

  task automatic op_wr_tx(input logic [7:0] d);
    logic [31:0] r;
    if (m_full) m_txo = 1; else begin m_hold = d; m_full = 1; end
    wb_xfer(1, 32'h04, {24'h0, d}, r);
  endtask

  task automatic op_rd_rx();
    logic [31:0] r, e;
    e = (mq.size() == 0) ? 0 : {24'h0, mq.pop_front()};
    wb_xfer(0, 32'h00, 0, r);
    chk("rxdata", r, e);
  endtask

  task automatic op_rd_status();
    logic [31:0] r, e;
    int sz = mq.size();
    e = 0;
    e[1] = (sz == 0); e[2] = (sz == DEPTH); e[3] = m_full; e[6:4] = 3'(sz);
    wb_xfer(0, 32'h08, 0, r);
    chk("status", r, e);
  endtask

  task automatic op_rd_ris();
    logic [31:0] r;
    wb_xfer(0, 32'h14, 0, r);
    chk("ris", r, {27'h0, m_ris()});
  endtask

  task automatic op_wr_ris(input logic [4:0] v);
    logic [31:0] r;
    if (v[1]) m_ovr = 0;
    if (v[2]) m_uf = 0;
    if (v[3]) m_eof = 0;
    if (v[4]) m_txo = 0;
    wb_xfer(1, 32'h14, {27'h0, v}, r);
  endtask

  task automatic op_wr_im(input logic [4:0] v);
    logic [31:0] r;
    m_im = v;
    wb_xfer(1, 32'h10, {27'h0, v}, r);
  endtask

  task automatic op_wr_ctrl(input logic [1:0] v);
    logic [31:0] r;
    m_en = v[0];
    if (v[1]) mq.delete();
    wb_xfer(1, 32'h0C, {30'h0, v}, r);
  endtask

  task automatic chk_irq();
    chk("irq", {31'h0, IRQ}, {31'h0, |(m_ris() & m_im)});
  endtask

  // Mode-0 master: nb whole bytes from fb[] then pb extra bits, then csb high
  task automatic spi_frame(input int nb, input int pb);
    logic [7:0] got;
    int nbits;
    csb = 0;
    if (m_en) m_load();
    repeat (2*H) @(posedge clk); #1;
    chk("miso_oeb", {31'h0, miso_oeb}, {31'h0, ~m_en});
    for (int b = 0; b <= nb; b++) begin
      nbits = (b < nb) ? 8 : pb;
      got = 0;
      for (int i = 0; i < nbits; i++) begin
        mosi = fb[b][7-i];
        repeat (H) @(posedge clk); #1;
        got = {got[6:0], miso};
        sclk = 1;
        repeat (H) @(posedge clk); #1;
        sclk = 0;
      end
      if (b < nb && m_en) begin
        chk("miso_byte", {24'h0, got}, {24'h0, m_cur});
        if (mq.size() == DEPTH) m_ovr = 1; else mq.push_back(fb[b]);
        m_load();
      end
    end
    repeat (H) @(posedge clk); #1;
    csb = 1;
    if (m_en) m_eof = 1;
    repeat (2*H) @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] r;
    int op, nb, pb;
    m_reset();
    repeat (3) @(posedge clk); #1;
    chk("rst_ack", {31'h0, ack_o}, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_irq", {31'h0, IRQ}, 0);
    chk("rst_miso", {31'h0, miso}, 1);
    chk("rst_oeb", {31'h0, miso_oeb}, 1);
    rst_i = 0;
    op_rd_status();
    op_rd_ris();

    // Basic exchange
    op_wr_ctrl(2'b01);
    op_wr_tx(8'h3C);
    fb[0] = 8'hA5;
    spi_frame(1, 0);
    op_rd_ris();
    op_rd_rx();
    op_rd_ris();

    // Overflow with and without mask
    op_wr_ris(5'h1F);
    op_wr_im(5'h02);
    for (int i = 0; i < 5; i++) fb[i] = 8'(i + 1);
    spi_frame(5, 0);
    chk_irq();
    op_rd_status();
    op_wr_im(5'h00);
    chk_irq();
    for (int i = 0; i < 5; i++) op_rd_rx();

    // Underflow then clear
    op_wr_ris(5'h1F);
    fb[0] = 8'h5A;
    spi_frame(1, 0);
    op_rd_ris();
    op_wr_ris(5'h04);
    op_rd_ris();
    op_rd_rx();

    // Partial frame then full byte
    op_wr_ris(5'h1F);
    fb[0] = 8'hE7;
    spi_frame(0, 3);
    op_rd_ris();
    op_rd_status();
    fb[0] = 8'h96;
    spi_frame(1, 0);
    op_rd_rx();

    // TX overrun, unmapped read, flush
    op_wr_tx(8'h11);
    op_wr_tx(8'h22);
    op_rd_status();
    op_rd_ris();
    wb_xfer(0, 32'h18, 0, r);
    chk("unmapped", r, 0);
    fb[0] = 8'h42; fb[1] = 8'h24;
    spi_frame(2, 0);
    op_wr_ctrl(2'b11);
    op_rd_status();

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 8);
      case (op)
        0: op_wr_tx(8'($urandom));
        1: op_rd_rx();
        2: op_rd_status();
        3: op_rd_ris();
        4: op_wr_ris(5'($urandom));
        5: op_wr_im(5'($urandom));
        6: op_wr_ctrl({$urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0});
        default: begin
          nb = $urandom_range(0, 3);
          pb = $urandom_range(0, 7);
          if (nb == 0 && pb == 0) nb = 1;
          for (int i = 0; i < 8; i++) fb[i] = 8'($urandom);
          spi_frame(nb, pb);
        end
      endcase
      chk_irq();
    end

    // Reset in the middle of a byte
    op_wr_ctrl(2'b01);
    op_wr_im(5'h01);
    fb[0] = 8'hC3;
    spi_frame(1, 0);
    chk_irq();
    csb = 0;
    repeat (2*H) @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      mosi = i[0];
      repeat (H) @(posedge clk); #1;
      sclk = 1;
      repeat (H) @(posedge clk); #1;
      sclk = 0;
    end
    #3 rst_i = 1;
    #1;
    chk("mid_rst_oeb", {31'h0, miso_oeb}, 1);
    chk("mid_rst_irq", {31'h0, IRQ}, 0);
    chk("mid_rst_miso", {31'h0, miso}, 1);
    csb = 1; sclk = 0; mosi = 0;
    repeat (3) @(posedge clk); #1;
    rst_i = 0;
    m_reset();
    op_rd_status();
    op_rd_ris();
    wb_xfer(0, 32'h0C, 0, r);
    chk("ctrl_after_rst", r, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
